// File: rtl/led_pattern_driver_if.sv
// led_pattern_driver_if: config register handoff from the AXI4-Lite register bank to the LED driver.
interface led_pattern_driver_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] cfg_ctrl;
    logic [DATA_WIDTH-1:0] cfg_duty;
    logic [DATA_WIDTH-1:0] cfg_period;
    logic [DATA_WIDTH-1:0] cfg_pattern;
    logic                  cfg_valid;
    logic                  cfg_ack;
    logic                  busy;
    modport master (output cfg_ctrl, cfg_duty, cfg_period, cfg_pattern, cfg_valid, input cfg_ack, busy);
    modport slave  (input cfg_ctrl, cfg_duty, cfg_period, cfg_pattern, cfg_valid, output cfg_ack, busy);
endinterface

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: PWM-dimmed, animated LED outputs; config applied only at frame boundaries.
// Define LED_PATTERN_GAMMA_EN to square the duty value (gamma approximation) at apply time.
module led_pattern_driver #(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    led_pattern_driver_if.slave cfg,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame_tick
);
    localparam int IW = $clog2(NUM_LEDS);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {S_DIS, S_STATIC, S_BLINK, S_ROTATE, S_BOUNCE} state_t;

    state_t                state, stg_state;
    logic [3:0]            stg_ctrl;
    logic [PWM_BITS:0]     stg_duty;
    logic [DATA_WIDTH-1:0] stg_period, period, step_cnt;
    logic [NUM_LEDS-1:0]   stg_pattern, pat_reg, eff_pattern;
    logic [PWM_BITS-1:0]   duty_eff, stg_duty_eff, pwm_cnt;
    logic [IW-1:0]         idx;
    logic                  pending, invert, force_full, blink_phase, dir_up;
    logic                  en, apply, step_tick, pwm_on, bounce_up;
    logic                  unused_cfg;

    assign unused_cfg = ^{cfg.cfg_ctrl, cfg.cfg_duty, cfg.cfg_pattern};
    assign cfg.busy = pending;

`ifdef LED_PATTERN_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_ext;
    always_comb begin
        duty_ext     = (2*PWM_BITS)'(stg_duty[PWM_BITS-1:0]);
        stg_duty_eff = PWM_BITS'((duty_ext * duty_ext) >> PWM_BITS);
    end
`else
    always_comb stg_duty_eff = stg_duty[PWM_BITS-1:0];
`endif

    always_comb begin
        en          = state != S_DIS;
        apply       = pending && (!en || pwm_cnt == PWM_MAX);
        step_tick   = en && step_cnt == period;
        pwm_on      = force_full || (pwm_cnt < duty_eff);
        stg_state   = !stg_ctrl[0]           ? S_DIS    :
                      stg_ctrl[2:1] == 2'b00 ? S_STATIC :
                      stg_ctrl[2:1] == 2'b01 ? S_BLINK  :
                      stg_ctrl[2:1] == 2'b10 ? S_ROTATE : S_BOUNCE;
        eff_pattern = state == S_BLINK  ? (blink_phase ? '0 : pat_reg) :
                      state == S_BOUNCE ? NUM_LEDS'(1) << idx : pat_reg;
        // reverse direction at either end so endpoints are visited once
        bounce_up   = dir_up ? idx != IDX_MAX : idx == '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= S_DIS;
            stg_ctrl    <= '0;
            stg_duty    <= '0;
            stg_period  <= '0;
            stg_pattern <= '0;
            pending     <= 1'b0;
            invert      <= 1'b0;
            force_full  <= 1'b0;
            duty_eff    <= '0;
            period      <= '0;
            pat_reg     <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            idx         <= '0;
            dir_up      <= 1'b1;
            blink_phase <= 1'b0;
            cfg.cfg_ack <= 1'b0;
            frame_tick  <= 1'b0;
            led_out     <= '0;
        end else begin
            if (cfg.cfg_valid) begin
                stg_ctrl    <= cfg.cfg_ctrl[3:0];
                stg_duty    <= cfg.cfg_duty[PWM_BITS:0];
                stg_period  <= cfg.cfg_period;
                stg_pattern <= cfg.cfg_pattern[NUM_LEDS-1:0];
            end
            pending     <= cfg.cfg_valid || (pending && !apply);
            cfg.cfg_ack <= apply;
            frame_tick  <= en && pwm_cnt == PWM_MAX;
            pwm_cnt     <= en ? pwm_cnt + PWM_BITS'(1) : '0;
            led_out     <= en ? ((eff_pattern & {NUM_LEDS{pwm_on}}) ^ {NUM_LEDS{invert}}) : '0;
            if (apply) begin
                state       <= stg_state;
                invert      <= stg_ctrl[3];
                force_full  <= stg_duty[PWM_BITS];
                duty_eff    <= stg_duty_eff;
                period      <= stg_period;
                pat_reg     <= stg_pattern;
                step_cnt    <= '0;
                idx         <= '0;
                dir_up      <= 1'b1;
                blink_phase <= 1'b0;
            end else begin
                step_cnt <= (!en || step_tick) ? '0 : step_cnt + DATA_WIDTH'(1);
                if (step_tick) begin
                    case (state)
                        S_BLINK:  blink_phase <= !blink_phase;
                        S_ROTATE: pat_reg <= {pat_reg[NUM_LEDS-2:0], pat_reg[NUM_LEDS-1]};
                        S_BOUNCE: begin
                            idx    <= bounce_up ? idx + IW'(1) : idx - IW'(1);
                            dir_up <= bounce_up;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver: randomized scoreboard bench; configs queue an expected ack, monitor checks every cycle.
module tb_led_pattern_driver;
    localparam int N  = 4;
    localparam int PB = 8;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] duty;
        logic [31:0] period;
        logic [31:0] pattern;
        longint      k;
    } rec_t;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [N-1:0] led_out;
    logic         frame_tick;
    longint       cyc = 0;
    longint       x = 0;
    rec_t         q[$];
    rec_t         act = '{0, 0, 0, 0, 0};
    int           checks = 0;
    int           passed = 0;

    led_pattern_driver_if #(.DATA_WIDTH(DW)) cfg ();

    led_pattern_driver #(.NUM_LEDS(N), .PWM_BITS(PB), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg(cfg), .led_out(led_out), .frame_tick(frame_tick)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    // Output of the active config t cycles after its first active cycle, from the register semantics alone.
    function automatic void model(input rec_t a, input longint t, output logic [N-1:0] led, output logic ft);
        logic [N-1:0] pat, eff;
        longint s, r, p, d;
        logic on;
        led = '0;
        ft  = 1'b0;
        if (!a.ctrl[0]) return;
        p = t % 256;
        s = t / (longint'(a.period) + 1);
        d = longint'(a.duty[7:0]);
`ifdef LED_PATTERN_GAMMA_EN
        d = (d * d) / 256;
`endif
        on  = a.duty[8] || p < d;
        pat = a.pattern[N-1:0];
        case (a.ctrl[2:1])
            2'd0: eff = pat;
            2'd1: eff = (s % 2 != 0) ? '0 : pat;
            2'd2: begin
                r   = s % N;
                eff = (pat << r) | (pat >> (N - r));
            end
            default: begin
                r   = s % (2 * N - 2);
                eff = N'(1) << (r < N ? r : 2 * N - 2 - r);
            end
        endcase
        led = (on ? eff : '0) ^ {N{a.ctrl[3]}};
        ft  = p == 255;
    endfunction

    function automatic longint exp_ack(input rec_t r);
        longint c;
        if (!act.ctrl[0]) return r.k + 2;
        c = x + 255;
        while (c < r.k + 1) c += 256;
        return c + 1;
    endfunction

    initial begin
        logic [N-1:0] el;
        logic ef, ea;
        forever begin
            @(negedge ACLK);
            model(act, cyc - x - 1, el, ef);
            check("led_out", longint'(led_out), longint'(el));
            check("frame_tick", longint'(frame_tick), longint'(ef));
            ea = q.size() != 0 && cyc == exp_ack(q[0]);
            check("cfg_ack", longint'(cfg.cfg_ack), longint'(ea));
            if (q.size() != 0 && (cfg.cfg_ack || ea)) begin
                act = q.pop_front();
                x   = cyc;
            end
            check("busy", longint'(cfg.busy), longint'(q.size() != 0 && cyc >= q[0].k + 1));
            if (ARESET) begin
                act = '{0, 0, 0, 0, 0};
                x   = cyc;
                q.delete();
            end
        end
    end

    task automatic issue(input logic [31:0] c, input logic [31:0] d, input logic [31:0] p, input logic [31:0] pt);
        @(posedge ACLK);
        #2;
        cfg.cfg_ctrl    = c;
        cfg.cfg_duty    = d;
        cfg.cfg_period  = p;
        cfg.cfg_pattern = pt;
        cfg.cfg_valid   = 1'b1;
        if (q.size() != 0) q[0] = '{c, d, p, pt, q[0].k};
        else q.push_back('{c, d, p, pt, cyc});
        @(posedge ACLK);
        #2;
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 800) begin
            @(posedge ACLK);
            n++;
        end
        check("ack_wait_bound", longint'(n < 800), 1);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge ACLK);
    endtask

    initial begin
        cfg.cfg_ctrl    = '0;
        cfg.cfg_duty    = '0;
        cfg.cfg_period  = '0;
        cfg.cfg_pattern = '0;
        cfg.cfg_valid   = 1'b0;
        run(3);
        #2 ARESET = 1'b0;
        issue(32'h1, 32'h80, 0, 32'hF);
        wait_idle();
        run(600);
        issue(32'h3, 32'h100, 9, 32'h5);
        wait_idle();
        run(60);
        issue(32'h5, 32'h100, 0, 32'h1);
        wait_idle();
        run(20);
        issue(32'h7, 32'h100, 0, 32'h0);
        wait_idle();
        run(20);
        issue(32'h1, 32'h40, 3, 32'hA);
        run(4);
        issue(32'h7, 32'h100, 2, 32'h0);
        wait_idle();
        run(100);
        issue(32'h9, 32'h0, 0, 32'hF);
        wait_idle();
        run(300);
        issue(32'h5, 32'h100, 0, 32'h3);
        run(3);
        @(posedge ACLK);
        #2 ARESET = 1'b1;
        run(2);
        @(posedge ACLK);
        #2 ARESET = 1'b0;
        run(300);
        repeat (14) begin
            issue(($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0),
                  32'($urandom_range(0, 511)), 32'($urandom_range(0, 20)), $urandom);
            wait_idle();
            run($urandom_range(30, 400));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
